prog_load_seq: RTL and testbench

- Program-load sequencer sitting directly downstream of the 32-word bootstrap ROM.
- On an operator program-load request while the CPU is halted, it walks ROM addresses 0–31 and writes each word into core memory locations BASE_ADDR..BASE_ADDR+31 (octal 0–37 by default) through the memory write handshake.
- It then presents START_PC to the CPU and pulses a start strobe.
- Its ack watchdog flags a hung memory without wedging the panel.

---
 rtl/prog_load_seq.sv | 217 +++++++++++++++++++++
 tb/tb_prog_load_seq.sv | 364 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prog_load_seq.sv
// ---------------------------------------------------------------------------
// prog_load_seq
//
// Program-load sequencer that sits behind the 32-word bootstrap ROM. When the
// operator raises pl_req while the CPU is halted, it copies ROM words 0..31
// into core locations BASE_ADDR..BASE_ADDR+31 over the memory write handshake.
// It then presents START_PC on cpu_pc together with a one-cycle cpu_start
// strobe. If memory does not ack a word within ACK_TIMEOUT cycles, the load is
// abandoned, load_err is set and the sequencer returns to idle. This keeps a
// hung memory from locking up the panel.
//
// Optional feature macro: PROG_LOAD_SWITCH_DEVCODE_EN
//   When defined, word 31 is taken from the front-panel switches (sw_data)
//   instead of the ROM, so the operator can choose the boot device code.
//   When undefined, sw_data is ignored.
//
// Parameters:
//   AW          memory address width
//   BASE_ADDR   first core location written
//   START_PC    program counter handed to the CPU on completion
//   ACK_TIMEOUT max WRITE cycles per word before abort (1..65535)
//
// Ports:
//   clk, rst      clock; asynchronous active-high reset
//   pl_req        program-load request (level, rising edge acts)
//   cpu_halted    load accepted only while 1
//   rom_addr      bootstrap ROM address (out)
//   rom_data      ROM word for rom_addr (combinational, in)
//   sw_data       panel data switches (used only with the optional feature)
//   mem_req       memory write request (out)
//   mem_we        write enable, identical to mem_req (out)
//   mem_addr      memory address (out)
//   mem_wdata     memory write data (out)
//   mem_ack       one-cycle write accept from memory (in)
//   cpu_pc        start address, valid with cpu_start (out)
//   cpu_start     one-cycle start strobe (out)
//   busy          load in progress (out)
//   load_err      sticky ack-timeout flag (out)
// ---------------------------------------------------------------------------
module prog_load_seq #(
   parameter int AW          = 15,
   parameter int BASE_ADDR   = 0,
   parameter int START_PC    = 0,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          pl_req,
   input  logic          cpu_halted,
   output logic [4:0]    rom_addr,
   input  logic [15:0]   rom_data,
   input  logic [15:0]   sw_data,
   output logic          mem_req,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [15:0]   mem_wdata,
   input  logic          mem_ack,
   output logic [AW-1:0] cpu_pc,
   output logic          cpu_start,
   output logic          busy,
   output logic          load_err
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_WRITE = 2'd2,
      S_START = 2'd3
   } state_t;

   localparam logic [AW-1:0] BASE      = AW'(BASE_ADDR);
   localparam logic [AW-1:0] PC_START  = AW'(START_PC);
   // Last watchdog value at which an ack is still accepted; with no ack in
   // that cycle the request has been up for exactly ACK_TIMEOUT cycles.
   localparam logic [15:0]   WDOG_LAST = 16'(ACK_TIMEOUT - 1);

   state_t        r_state;
   state_t        w_state_next;

   logic          r_pl_req_d;
   logic [4:0]    r_cnt;
   logic [15:0]   r_wdog;
   logic [4:0]    r_rom_addr;
   logic [AW-1:0] r_mem_addr;
   logic [15:0]   r_mem_wdata;
   logic [AW-1:0] r_cpu_pc;
   logic          r_load_err;

   logic          w_go;
   logic          w_accept;
   logic          w_last;
   logic          w_wdog_expired;
   logic [15:0]   w_fetch_data;

   // Rising edge of the request. Edges that cannot be served are simply lost.
   assign w_go           = pl_req & ~r_pl_req_d;
   assign w_accept       = w_go & cpu_halted & (r_state == S_IDLE);
   assign w_last         = (r_cnt == 5'd31);
   assign w_wdog_expired = (r_wdog == WDOG_LAST);

`ifdef PROG_LOAD_SWITCH_DEVCODE_EN
   // Word 31 carries the boot device code; the panel switches override it.
   assign w_fetch_data = w_last ? sw_data : rom_data;
`else
   assign w_fetch_data = rom_data;
   logic w_unused_sw;
   assign w_unused_sw = ^sw_data;
`endif

   // ---------------- state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_state_next = S_FETCH;
         end
         S_FETCH: begin
            w_state_next = S_WRITE;
         end
         S_WRITE: begin
            if (mem_ack) begin
               w_state_next = w_last ? S_START : S_FETCH;
            end else if (w_wdog_expired) begin
               w_state_next = S_IDLE;
            end
         end
         S_START: begin
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   // ---------------- state-decoded outputs ----------------
   // The request is decoded straight from the state, so an asynchronous
   // reset drops it immediately.
   always_comb begin
      mem_req   = 1'b0;
      cpu_start = 1'b0;
      busy      = 1'b0;
      case (r_state)
         S_FETCH: busy = 1'b1;
         S_WRITE: begin
            busy    = 1'b1;
            mem_req = 1'b1;
         end
         S_START: cpu_start = 1'b1;
         default: ;
      endcase
   end

   assign mem_we    = mem_req;
   assign rom_addr  = r_rom_addr;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_pc    = r_cpu_pc;
   assign load_err  = r_load_err;

   // ---------------- datapath registers ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pl_req_d  <= 1'b0;
         r_cnt       <= 5'd0;
         r_wdog      <= 16'd0;
         r_rom_addr  <= 5'd0;
         r_mem_addr  <= '0;
         r_mem_wdata <= 16'd0;
         r_cpu_pc    <= '0;
         r_load_err  <= 1'b0;
      end else begin
         r_pl_req_d <= pl_req;
         case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_load_err <= 1'b0;
                  r_cnt      <= 5'd0;
                  r_rom_addr <= 5'd0;
               end
            end
            S_FETCH: begin
               // Address arithmetic wraps modulo 2^AW.
               r_mem_addr  <= BASE + AW'(r_cnt);
               r_mem_wdata <= w_fetch_data;
               // Every entry to WRITE starts with a fresh watchdog.
               r_wdog      <= 16'd0;
            end
            S_WRITE: begin
               if (mem_ack) begin
                  if (w_last) begin
                     r_cpu_pc <= PC_START;
                  end else begin
                     r_cnt      <= r_cnt + 5'd1;
                     r_rom_addr <= r_cnt + 5'd1;
                  end
               end else if (w_wdog_expired) begin
                  r_load_err <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + 16'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_load_seq.sv
// ---------------------------------------------------------------------------
// tb_prog_load_seq
//
// Scoreboard bench for prog_load_seq. Each accepted load pushes its expected
// writes (location, word) and its start PC into queues. A monitor pops and
// compares them on every accepted write (mem_req & mem_ack) and on every
// cpu_start. A memory model acks each request after a random latency, can
// refuse to ack one chosen address, and can raise stray acks outside writes.
// ---------------------------------------------------------------------------
module tb_prog_load_seq;

   localparam int AW   = 15;
   localparam int BASE = 32752;      // 2^15 - 16: the load wraps past address 0
   localparam int SPC  = 'o200;
   localparam int TMO  = 255;

   logic          clk = 1'b0;
   logic          rst;
   logic          pl_req;
   logic          cpu_halted;
   logic [4:0]    rom_addr;
   logic [15:0]   rom_data;
   logic [15:0]   sw_data;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [15:0]   mem_wdata;
   logic          mem_ack;
   logic [AW-1:0] cpu_pc;
   logic          cpu_start;
   logic          busy;
   logic          load_err;

   always #5 clk = ~clk;

   prog_load_seq #(
      .AW(AW), .BASE_ADDR(BASE), .START_PC(SPC), .ACK_TIMEOUT(TMO)
   ) dut (
      .clk(clk), .rst(rst), .pl_req(pl_req), .cpu_halted(cpu_halted),
      .rom_addr(rom_addr), .rom_data(rom_data), .sw_data(sw_data),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ack(mem_ack), .cpu_pc(cpu_pc),
      .cpu_start(cpu_start), .busy(busy), .load_err(load_err)
   );

   // Bootstrap ROM contents (combinational read).
   logic [15:0] rom [32];
   assign rom_data = rom[rom_addr];

   typedef struct {
      logic [AW-1:0] addr;
      logic [15:0]   data;
   } wr_t;

   wr_t           exp_wr[$];
   logic [AW-1:0] exp_pc[$];

   int checks = 0;
   int errors = 0;

   // Memory model controls.
   int            lat_max   = 0;
   bit            spur_en   = 1'b0;
   bit            hang_en   = 1'b0;
   logic [AW-1:0] hang_addr = '0;
   int            exp_busy  = 0;

   // Monitor state.
   bit            prev_req  = 1'b0;
   logic [AW-1:0] prev_addr = '0;
   logic [15:0]   prev_data = '0;
   bit            stable_ok = 1'b1;
   int            busy_len  = 0;
   int            last_busy_len = 0;
   int            req_run   = 0;
   int            last_req_run  = 0;
   logic [15:0]   img [32];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference model: a load copies ROM words 0..n-1 to BASE+i (mod 2^AW)
   // and, if it runs to word 31, hands SPC to the CPU.
   task automatic push_load(input int hang_word);
      int n;
      wr_t w;
      logic [AW-1:0] pc;
      n = (hang_word < 0) ? 32 : hang_word;
      for (int i = 0; i < n; i++) begin
         w.addr = AW'((BASE + i) % (1 << AW));
         w.data = rom[i];
`ifdef PROG_LOAD_SWITCH_DEVCODE_EN
         if (i == 31) w.data = sw_data;
`endif
         exp_wr.push_back(w);
      end
      if (hang_word < 0) begin
         pc = AW'(SPC);
         exp_pc.push_back(pc);
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_rom_addr"},  32'(rom_addr),  0);
      chk({tag, "_mem_req"},   32'(mem_req),   0);
      chk({tag, "_mem_we"},    32'(mem_we),    0);
      chk({tag, "_mem_addr"},  32'(mem_addr),  0);
      chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
      chk({tag, "_cpu_pc"},    32'(cpu_pc),    0);
      chk({tag, "_cpu_start"}, 32'(cpu_start), 0);
      chk({tag, "_busy"},      32'(busy),      0);
      chk({tag, "_load_err"},  32'(load_err),  0);
   endtask

   task automatic pulse_pl();
      @(posedge clk); #1 pl_req = 1'b1;
      @(posedge clk); #1 pl_req = 1'b0;
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int n = 0;
      while (busy === 1'b1 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      chk({tag, "_finished"}, 32'(busy), 0);
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic run_load(input string tag, input bit mid_pulse, input bit halt_drop);
      push_load(-1);
      exp_busy = 0;
      pulse_pl();
      if (mid_pulse || halt_drop) begin
         repeat (20) @(posedge clk);
         #1;
         if (mid_pulse) pl_req = 1'b1;
         if (halt_drop) cpu_halted = 1'b0;
         @(posedge clk); #1 pl_req = 1'b0;
      end
      wait_idle(2000, tag);
      chk({tag, "_busy_len"}, 32'(last_busy_len), 32'(exp_busy));
      chk({tag, "_wr_left"},  32'(exp_wr.size()), 0);
      chk({tag, "_pc_left"},  32'(exp_pc.size()), 0);
      chk({tag, "_pc_hold"},  32'(cpu_pc), 32'(SPC));
      chk({tag, "_err"},      32'(load_err), 0);
      cpu_halted = 1'b1;
   endtask

   // Memory model: acks request in its lat-th cycle (lat 0 = first cycle).
   initial begin
      int k;
      int lat;
      k = 0;
      lat = 0;
      mem_ack = 1'b0;
      forever begin
         @(posedge clk); #1;
         if (rst) begin
            mem_ack = 1'b0;
            k = 0;
         end else if (mem_req) begin
            if (hang_en && mem_addr == hang_addr) mem_ack = 1'b0;
            else mem_ack = (k == lat);
            if (mem_ack) exp_busy += lat + 2;   // one FETCH + (lat+1) WRITE cycles
            k++;
         end else begin
            k = 0;
            lat = $urandom_range(0, lat_max);
            mem_ack = spur_en ? ($urandom_range(0, 3) == 0) : 1'b0;
         end
      end
   end

   // Monitor: pops the scoreboard on accepted writes and start strobes.
   initial begin
      wr_t w;
      logic [AW-1:0] pc;
      int off;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_req  = 1'b0;
            stable_ok = 1'b1;
            busy_len  = 0;
            req_run   = 0;
         end else begin
            if (mem_req) begin
               req_run++;
               if (mem_we !== 1'b1) stable_ok = 1'b0;
               if (prev_req && (mem_addr !== prev_addr || mem_wdata !== prev_data))
                  stable_ok = 1'b0;
               if (mem_ack) begin
                  if (exp_wr.size() == 0) begin
                     checks++;
                     errors++;
                     $display("FAIL unexpected_write: got addr %0h data %0o expected none",
                              mem_addr, mem_wdata);
                  end else begin
                     w = exp_wr.pop_front();
                     chk("wr_addr",   32'(mem_addr),  32'(w.addr));
                     chk("wr_data",   32'(mem_wdata), 32'(w.data));
                     chk("wr_stable", 32'(stable_ok), 1);
                  end
                  off = (int'(mem_addr) - BASE) & ((1 << AW) - 1);
                  if (off < 32) img[off] = mem_wdata;
                  stable_ok = 1'b1;
                  req_run = 0;
               end
            end else if (req_run > 0) begin
               last_req_run = req_run;
               req_run = 0;
               stable_ok = 1'b1;
            end
            prev_req  = mem_req & ~mem_ack;
            prev_addr = mem_addr;
            prev_data = mem_wdata;

            if (cpu_start) begin
               if (exp_pc.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_start: got pc %0h expected none", cpu_pc);
               end else begin
                  pc = exp_pc.pop_front();
                  chk("start_pc", 32'(cpu_pc), 32'(pc));
               end
            end

            if (busy) busy_len++;
            else if (busy_len > 0) begin
               last_busy_len = busy_len;
               busy_len = 0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1, "simulation time limit");
   end

   initial begin
      logic [15:0] exp31;
      int n;
      rom = '{16'o062677, 16'o012706, 16'o000776, 16'o005000, 16'o012701,
              16'o177560, 16'o105711, 16'o100376, 16'o116160, 16'o000002,
              16'o005200, 16'o000771, 16'o000000, 16'o177777, 16'o125252,
              16'o052525, 16'o000001, 16'o100000, 16'o007400, 16'o170017,
              16'o034343, 16'o143434, 16'o066666, 16'o111111, 16'o000377,
              16'o177400, 16'o012345, 16'o054321, 16'o003003, 16'o070707,
              16'o123456, 16'o100033};
      rst = 1'b1;
      pl_req = 1'b0;
      cpu_halted = 1'b1;
      sw_data = 16'o000033;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_reset("reset");
      @(posedge clk); #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Basic load: ack in the first request cycle, 2 cycles per word.
      run_load("basic", 1'b0, 1'b0);
      chk("basic_busy64", 32'(last_busy_len), 64);
      chk("basic_loc0",   32'(img[0]), 32'(16'o062677));
`ifdef PROG_LOAD_SWITCH_DEVCODE_EN
      exp31 = sw_data;
`else
      exp31 = 16'o100033;
`endif
      chk("basic_loc31", 32'(img[31]), 32'(exp31));

      // Random ack latency, stray acks, changing switches, ignored extra
      // requests and cpu_halted dropping mid-load.
      lat_max = 7;
      spur_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         sw_data = 16'($urandom);
         run_load("rand", (i == 1) || (i == 3), (i >= 2));
      end

      // Request while the CPU runs: dropped, not queued.
      cpu_halted = 1'b0;
      pulse_pl();
      repeat (5) @(posedge clk);
      #1;
      chk("nohalt_busy", 32'(busy), 0);
      cpu_halted = 1'b1;
      repeat (5) @(posedge clk);
      #1;
      chk("nohalt_not_queued", 32'(busy), 0);

      // Request held high across a whole load: exactly one load.
      push_load(-1);
      exp_busy = 0;
      @(posedge clk); #1 pl_req = 1'b1;
      @(posedge clk); #1;
      wait_idle(2000, "held");
      repeat (10) @(posedge clk);
      #1;
      chk("held_busy", 32'(busy), 0);
      chk("held_wr_left", 32'(exp_wr.size()), 0);
      chk("held_pc_left", 32'(exp_pc.size()), 0);
      pl_req = 1'b0;

      // Memory hangs on word 5: abort after TMO request cycles.
      hang_en = 1'b1;
      hang_addr = AW'((BASE + 5) % (1 << AW));
      push_load(5);
      pulse_pl();
      wait_idle(2000, "hang");
      chk("hang_req_cycles", 32'(last_req_run), 32'(TMO));
      chk("hang_err",  32'(load_err), 1);
      chk("hang_busy", 32'(busy), 0);
      chk("hang_wr_left", 32'(exp_wr.size()), 0);
      hang_en = 1'b0;

      // A clean load clears the error as soon as it is accepted.
      push_load(-1);
      exp_busy = 0;
      pulse_pl();
      chk("err_cleared", 32'(load_err), 0);
      wait_idle(2000, "after_hang");
      chk("after_hang_wr_left", 32'(exp_wr.size()), 0);
      chk("after_hang_pc_left", 32'(exp_pc.size()), 0);

      // Asynchronous reset while word 10 is being written.
      push_load(-1);
      pulse_pl();
      n = 0;
      while (!(mem_req === 1'b1 && mem_addr == AW'((BASE + 10) % (1 << AW))) && n < 500) begin
         @(posedge clk); #1;
         n++;
      end
      chk("rst_reached_word10", 32'(mem_req), 1);
      #3 rst = 1'b1;
      #1 check_reset("rst_mid");
      exp_wr.delete();
      exp_pc.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      sw_data = 16'o000033;
      run_load("after_rst", 1'b0, 1'b0);
      chk("after_rst_loc0", 32'(img[0]), 32'(16'o062677));

      chk("final_wr_left", 32'(exp_wr.size()), 0);
      chk("final_pc_left", 32'(exp_pc.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
